// File: rtl/axis_img_win3x3_gen.sv
// 3x3 neighbourhood generator for a single-pixel-bordered AXI4-Stream image.
// Optional build macro AXIS_IMG_WIN3X3_ERR_CNT_EN adds the saturating err_cnt port.
module axis_img_win3x3_gen #(
    parameter int IMG_RES_X = 336,
    parameter int IMG_RES_Y = 256
) (
    input  logic         axis_aclk,
    input  logic         axis_areset,
    input  logic [15:0]  s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    input  logic [1:0]   s_axis_tuser,
    output logic [143:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         m_axis_tuser,
    output logic         sync_err
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
    ,
    output logic [15:0]  err_cnt
`endif
);

    localparam int          LB_DEPTH = IMG_RES_X + 2;
    localparam int          AW       = $clog2(LB_DEPTH);
    localparam logic [15:0] X_LAST   = 16'(IMG_RES_X + 1);
    localparam logic [15:0] Y_LAST   = 16'(IMG_RES_Y + 1);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   x_cnt;
    logic [15:0]   y_cnt;
    logic [15:0]   lb1 [LB_DEPTH];
    logic [15:0]   lb2 [LB_DEPTH];
    logic [AW-1:0] lb_addr;
    logic [47:0]   col_prev2_q;
    logic [47:0]   col_prev1_q;
    logic [47:0]   col_new;
    logic [143:0]  win_next;
    logic          accept;
    logic          x_at_end;
    logic          row_end;
    logic          len_err;
    logic          emit;
    logic          sof;
    logic          unused_inputs;

    // Upstream tlast arrives mid-row and tuser[0] carries nothing we use.
    assign unused_inputs = s_axis_tlast ^ s_axis_tuser[0];

    // Handshake: a beat moves when valid and ready are both high at the clock
    // edge; ready may rise without valid and the output holds while stalled.
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign lb_addr  = x_cnt[AW-1:0];
    assign x_at_end = (x_cnt == X_LAST);
    assign row_end  = s_axis_tuser[1] | x_at_end;
    assign len_err  = s_axis_tuser[1] ^ x_at_end;
    assign emit     = (state == ST_ACTIVE) && (x_cnt >= 16'd2) && (y_cnt >= 16'd2);
    assign sof      = (x_cnt == 16'd2) && (y_cnt == 16'd2);

    // Columns are packed {top, middle, bottom}; lb2 holds row y-2, lb1 row y-1.
    assign col_new = {lb2[lb_addr], lb1[lb_addr], s_axis_tdata};

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[16*(3*r+0) +: 16] = col_prev2_q[16*(2-r) +: 16];
            win_next[16*(3*r+1) +: 16] = col_prev1_q[16*(2-r) +: 16];
            win_next[16*(3*r+2) +: 16] = col_new[16*(2-r) +: 16];
        end
    end

    always_comb begin
        state_next = state;
        if (accept && row_end) begin
            case (state)
                ST_FILL:   if (y_cnt == 16'd1) state_next = ST_ACTIVE;
                ST_ACTIVE: if (y_cnt == Y_LAST) state_next = ST_FILL;
                default:   state_next = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Line buffers are not reset; stale contents are never emitted after a restart.
    always_ff @(posedge axis_aclk) begin
        if (accept) begin
            lb2[lb_addr] <= lb1[lb_addr];
            lb1[lb_addr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            col_prev2_q <= '0;
            col_prev1_q <= '0;
            sync_err    <= 1'b0;
        end else if (accept) begin
            col_prev2_q <= col_prev1_q;
            col_prev1_q <= col_new;
            if (len_err) sync_err <= 1'b1;
            if (row_end) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    // Single output register: load on a producing beat, otherwise drain when taken.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (accept && emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= win_next;
            m_axis_tlast  <= row_end;
            m_axis_tuser  <= sof;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            err_cnt <= '0;
        end else if (accept && len_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_img_win3x3_gen.sv
// Self-checking bench for axis_img_win3x3_gen on a 4x3 image (6x5 bordered).
// Windows are predicted from a bordered-image pixel function and scoreboarded.
module tb_axis_img_win3x3_gen;

    localparam int RX = 4;
    localparam int RY = 3;
    localparam int BW = RX + 2;
    localparam int BH = RY + 2;
    localparam int EW = 147;

    logic         clk = 1'b0;
    logic         areset;
    logic [15:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [1:0]   s_tuser;
    logic [143:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic         m_tuser;
    logic         sync_err;
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
    logic [15:0]  err_cnt;
`endif

    int checks     = 0;
    int failures   = 0;
    int valid_pct  = 100;
    int ready_pct  = 100;
    int n_seen     = 0;
    logic hold       = 1'b0;
    logic ignore_out = 1'b0;

    // {dont_care_data, tuser, tlast, tdata}
    logic [EW-1:0] exp_q[$];

    typedef struct {
        string name;
        int    frames;
        int    vpct;
        int    rpct;
        int    exp_windows;
    } tc_t;

    tc_t tcs[4];

    axis_img_win3x3_gen #(
        .IMG_RES_X(RX),
        .IMG_RES_Y(RY)
    ) dut (
        .axis_aclk    (clk),
        .axis_areset  (areset),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .sync_err     (sync_err)
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input int x, input int y);
        if (x == 0 || x == BW - 1 || y == 0 || y == BH - 1) return 16'h0000;
        return 16'h1000 + 16'(16 * (y - 1)) + 16'(x - 1);
    endfunction

    function automatic logic [143:0] win_of(input int x, input int y);
        logic [143:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[16*(3*r+c) +: 16] = pix(x - 2 + c, y - 2 + r);
        return w;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drivers
    initial forever begin
        @(posedge clk);
        #2;
        m_tready = hold ? 1'b0 : ($urandom_range(99) < ready_pct);
    end

    task automatic send_beat(input logic [15:0] d, input logic eol);
        int   n;
        logic acc;
        while ($urandom_range(99) >= valid_pct) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tdata  = d;
        s_tuser  = {eol, 1'($urandom_range(1))};
        s_tlast  = 1'($urandom_range(1));
        s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout: got no s_axis_tready expected accept within 1000 cycles");
                break;
            end
        end
    endtask

    task automatic send_row(input int y, input int len, input bit eol_last, input int dc_from);
        for (int x = 0; x < len; x++) begin
            if (y >= 2 && x >= 2)
                exp_q.push_back({(x >= dc_from), (x == 2 && y == 2), (x == len - 1), win_of(x, y)});
            send_beat(pix(x, y), (x == len - 1) && eol_last);
        end
    endtask

    task automatic send_frame();
        for (int y = 0; y < BH; y++) send_row(y, BW, 1'b1, 99);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending windows expected 0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Scoreboard
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!areset && m_tvalid && m_tready && !ignore_out) begin
                n_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_window: got %h expected none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tuser !== e[145] || m_tlast !== e[144] ||
                        (!e[146] && m_tdata !== e[143:0])) begin
                        failures++;
                        $display("FAIL window_%0d: got user=%b last=%b data=%h expected user=%b last=%b data=%h",
                                 n_seen, m_tuser, m_tlast, m_tdata, e[145], e[144], e[143:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        tcs[0] = '{"nominal",       1, 100, 100, 12};
        tcs[1] = '{"back_to_back",  2, 100, 100, 24};
        tcs[2] = '{"random_50",     2,  50,  50, 24};
        tcs[3] = '{"random_skewed", 1,  30,  70, 12};

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid",   160'(m_tvalid), 160'(0));
        check("rst_tlast",    160'(m_tlast),  160'(0));
        check("rst_tuser",    160'(m_tuser),  160'(0));
        check("rst_tdata",    160'(m_tdata),  160'(0));
        check("rst_sync_err", 160'(sync_err), 160'(0));
        check("rst_s_tready", 160'(s_tready), 160'(1));
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
        check("rst_err_cnt",  160'(err_cnt),  160'(0));
`endif
        areset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            valid_pct = tcs[t].vpct;
            ready_pct = tcs[t].rpct;
            n_seen    = 0;
            for (int f = 0; f < tcs[t].frames; f++) send_frame();
            s_tvalid = 1'b0;
            drain();
            check({tcs[t].name, "_count"},    160'(n_seen),   160'(tcs[t].exp_windows));
            check({tcs[t].name, "_sync_err"}, 160'(sync_err), 160'(0));
        end

        // Backpressure mid-frame: output held, input stalled
        valid_pct = 100;
        ready_pct = 100;
        n_seen    = 0;
        fork
            send_frame();
            begin : bp
                logic [143:0] d0;
                logic         l0;
                logic         u0;
                int           n;
                repeat (14) @(posedge clk);
                #1;
                hold = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!m_tvalid && n < 20);
                d0 = m_tdata;
                l0 = m_tlast;
                u0 = m_tuser;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_tdata",    160'(m_tdata),  160'(d0));
                    check("bp_tvalid",   160'(m_tvalid), 160'(1));
                    check("bp_tlast",    160'(m_tlast),  160'(l0));
                    check("bp_tuser",    160'(m_tuser),  160'(u0));
                    check("bp_s_tready", 160'(s_tready), 160'(0));
                end
                @(posedge clk);
                #1;
                hold = 1'b0;
            end
        join
        s_tvalid = 1'b0;
        drain();
        check("bp_count", 160'(n_seen), 160'(12));

        // Short row 2 (tuser[1] at x=3): realigns to row 3
        n_seen = 0;
        send_row(0, BW, 1'b1, 99);
        send_row(1, BW, 1'b1, 99);
        send_row(2, 4,  1'b1, 99);
        send_row(3, BW, 1'b1, 4);
        send_row(4, BW, 1'b1, 4);
        s_tvalid = 1'b0;
        drain();
        check("err_count",    160'(n_seen),   160'(10));
        check("err_sync_err", 160'(sync_err), 160'(1));
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
        check("err_err_cnt",  160'(err_cnt),  160'(1));
`endif
        n_seen = 0;
        send_frame();
        s_tvalid = 1'b0;
        drain();
        check("post_err_count",  160'(n_seen),   160'(12));
        check("post_err_sticky", 160'(sync_err), 160'(1));

        // Mid-frame reset during row 3
        ignore_out = 1'b1;
        for (int y = 0; y < 3; y++) send_row(y, BW, 1'b1, 99);
        send_row(3, 2, 1'b0, 99);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_tvalid",   160'(m_tvalid), 160'(0));
        check("mrst_tlast",    160'(m_tlast),  160'(0));
        check("mrst_tuser",    160'(m_tuser),  160'(0));
        check("mrst_tdata",    160'(m_tdata),  160'(0));
        check("mrst_sync_err", 160'(sync_err), 160'(0));
        areset = 1'b0;
        exp_q.delete();
        ignore_out = 1'b0;
        n_seen = 0;
        send_frame();
        s_tvalid = 1'b0;
        drain();
        check("post_rst_count",    160'(n_seen),   160'(12));
        check("post_rst_sync_err", 160'(sync_err), 160'(0));
`ifdef AXIS_IMG_WIN3X3_ERR_CNT_EN
        check("post_rst_err_cnt",  160'(err_cnt),  160'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_img_win3x3_gen.md
Name: axis_img_win3x3_gen

Overview:
- Consumes the single-pixel-bordered AXI4-Stream image, (IMG_RES_X+2) x (IMG_RES_Y+2) pixels.
- Emits one 3x3 pixel neighbourhood per original image pixel, IMG_RES_X x IMG_RES_Y windows per frame, for the downstream BPR/filter kernels.
- Uses two internal line buffers plus a 3-column shift window, with a registered AXI4-Stream master output.

Parameters:
- IMG_RES_X, 336, original (unbordered) image width in pixels.
- IMG_RES_Y, 256, original (unbordered) image height in pixels.

Ports:
- axis_aclk  input  1  clock.
- axis_areset  input  1  reset. Synchronous, active-high.
- s_axis_tdata  input  16  bordered pixel.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- s_axis_tlast  input  1  ignored (upstream asserts it mid-row).
- s_axis_tuser  input  2  [1] = last border pixel of row; [0] ignored.
- m_axis_tdata  output  144  window. Bits [16*(3*r+c)+15 : 16*(3*r+c)]; r=0 top row, c=0 left column; centre pixel is [79:64].
- m_axis_tvalid  output  1  window valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last window of an output row.
- m_axis_tuser  output  1  first window of a frame (SOF).
- sync_err  output  1  sticky row-length mismatch flag.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, sync_err=0.
  - x_cnt=0, y_cnt=0 (16-bit each); state=ST_FILL.
  - Line buffer contents are not cleared.
- Reset asserted mid-frame aborts the frame. The next accepted beat is treated as bordered pixel (0,0).
- Input handshake:
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (single output register, no bubbles at full rate).
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
- Per accepted beat at bordered coordinates (x_cnt, y_cnt):
  - Read lb1[x_cnt] (row y-1) and lb2[x_cnt] (row y-2).
  - Write lb2[x_cnt] <= lb1[x_cnt] and lb1[x_cnt] <= s_axis_tdata.
  - Shift the window left by one column. The new right column is {lb2 value, lb1 value, s_axis_tdata} (top, middle, bottom).
  - Line buffers are IMG_RES_X+2 entries deep, with read-before-write semantics at the same address.
- Window emission: a window is produced for an accepted beat when x_cnt>=2 and y_cnt>=2. Its centre is bordered pixel (x_cnt-1, y_cnt-1).
- Output register:
  - Loaded on the clock edge of the producing handshake, so latency is 1 cycle from accepted input to m_axis_tvalid=1.
  - m_axis_tlast=1 when the producing beat is a row-ending beat.
  - m_axis_tuser=1 when x_cnt==2 and y_cnt==2.
  - If an accepted beat produces no window and m_axis_tready=1, m_axis_tvalid clears.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs are held stable.
- Row end: a beat is row-ending if s_axis_tuser[1]=1 OR x_cnt==IMG_RES_X+1, whichever comes first.
  - On a row-ending beat: x_cnt<=0 and y_cnt<=y_cnt+1.
  - If y_cnt==IMG_RES_Y+1, y_cnt<=0 instead (frame wrap).
  - If tuser[1]=1 and x_cnt!=IMG_RES_X+1, or tuser[1]=0 and x_cnt==IMG_RES_X+1: sync_err<=1.
  - sync_err is sticky until reset. Processing continues, realigned to the row end.
- FSM:
  - ST_FILL: y_cnt<2, no windows emitted. Moves to ST_ACTIVE on the row-ending beat of row 1.
  - ST_ACTIVE: windows emitted per the rule above. Moves to ST_FILL on the row-ending beat of row IMG_RES_Y+1.
- Simultaneous events: an output-register load and a downstream acceptance in the same cycle replace the held window with no gap.

Optional Feature:
- Macro: AXIS_IMG_WIN3X3_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt[15:0], reset value 0.
  - Increments once per detected row-length mismatch and saturates at 16'hFFFF.
  - sync_err is unchanged.
- Undefined: port and counter are absent; only sync_err is provided.

Test Plan:
- Nominal frame, IMG_RES_X=4, IMG_RES_Y=3:
  - Stimulus: 6x5 bordered frame; borders 16'h0000; data pixel (i,j) = 16'h1000+16'h10*j+i; tready=1, tvalid=1 continuously.
  - Exactly 12 windows. First window rows are {0000,0000,0000}, {0000,1000,1001}, {0000,1010,1011}.
  - tlast on windows 4, 8, 12. tuser only on window 1. sync_err=0.
- Back-to-back frames: send two identical frames with no gap -> 24 windows. Window 13 equals window 1 and has tuser=1.
- Backpressure: hold m_axis_tready=0 for 5 cycles mid-row -> m_axis_tdata/tvalid/tlast stable, s_axis_tready=0. Sequence unchanged after release.
- Row-length error: assert s_axis_tuser[1] on x_cnt=3 of row 2 -> sync_err=1 (err_cnt=1 when the macro is defined). The next beat is treated as x_cnt=0 of row 3.
- Mid-frame reset: pulse axis_areset for 1 cycle during row 3, then send a full clean frame -> all outputs 0 during reset, then 12 correct windows and sync_err=0.
- Random tvalid/tready duty of 50%: window sequence is identical to the nominal case and no beats are dropped or duplicated.
